// File: rtl/dmem_wait_responder_if.sv
// Data-memory bus between the MEM-stage requestor (master) and the
// wait-state responder (slave).
interface dmem_wait_responder_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        ready;
  logic        stall;
  logic        err;

  modport master (
    output MemRead, MemWrite, addr, wd,
    input  rd, ready, stall, err
  );

  modport slave (
    input  MemRead, MemWrite, addr, wd,
    output rd, ready, stall, err
  );
endinterface

// File: rtl/dmem_wait_responder.sv
// Word-addressed data memory that answers each MEM-stage access after a fixed
// number of wait states, holding the pipeline via stall until ready pulses.
module dmem_wait_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  dmem_wait_responder_if.slave  bus
);
  localparam int          IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_U = 32'(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("dmem_wait_responder: LATENCY must be within 1..15");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             op_write_q;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      wd_q;
  logic [31:0]      rd_q;
  logic             ready_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic        req;
  logic        bad;
  logic        accept;
  logic        commit;
  logic [29:0] word_idx;

  // Validity only matters in IDLE; later input changes are ignored.
  assign word_idx = bus.addr[31:2];
  assign req      = bus.MemRead | bus.MemWrite;
  assign bad      = (bus.MemRead & bus.MemWrite)
                  | (bus.addr[1:0] != 2'b00)
                  | ({2'b00, word_idx} >= DEPTH_U);
  assign accept   = ~rst & (state_q == IDLE) & req & ~bad;
  assign commit   = ~rst & (state_q == BUSY) & (cnt_q == 4'd0);

  assign bus.stall = accept | (~rst & (state_q == BUSY));
  assign bus.err   = ~rst & (state_q == IDLE) & req & bad;
  assign bus.rd    = rd_q;
  assign bus.ready = ready_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = BUSY;
          cnt_d   = CNT_INIT;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      op_write_q <= 1'b0;
      idx_q      <= '0;
      wd_q       <= 32'd0;
      rd_q       <= 32'd0;
      ready_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= commit;
      if (accept) begin
        op_write_q <= bus.MemWrite;
        idx_q      <= word_idx[IDX_W-1:0];
        wd_q       <= bus.wd;
      end
      if (commit && !op_write_q) begin
        rd_q <= mem[idx_q];
      end
    end
  end

  // Kept free of reset so the array maps onto block RAM; commit already
  // excludes reset, which is what discards a pending write.
  always_ff @(posedge clk) begin
    if (commit && op_write_q) begin
      mem[idx_q] <= wd_q;
    end
  end
endmodule

// File: tb/tb_dmem_wait_responder.sv
// Randomised scoreboard bench for dmem_wait_responder, plus two small
// instances exercising the latency extremes.
module tb_dmem_wait_responder;
  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  logic rst;
  logic rst_sw;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_wait_responder_if bus ();
  dmem_wait_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          kind;   // 0 read, 1 write, 2 rejected
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sbq [$];
  logic [31:0] ref_mem [DEPTH];
  int          st_lo = 1;
  int          st_hi = 0;
  int          sweep_done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for ready (cycle %0d)", name, cyc);
  endtask

  task automatic idle_bus();
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.addr     = 32'd0;
    bus.wd       = 32'd0;
  endtask

  // Issue one request; valid ones are held until ready, rejected ones for one cycle.
  task automatic issue(input bit rdn, input bit wrn, input logic [31:0] a,
                       input logic [31:0] d, input bit junk);
    int   t;
    bit   is_bad;
    int   idx;
    exp_t e;
    bit   got;
    @(posedge clk); #1;
    bus.MemRead  = rdn;
    bus.MemWrite = wrn;
    bus.addr     = a;
    bus.wd       = d;
    t      = cyc;
    is_bad = (rdn && wrn) || (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH);
    if (is_bad) begin
      e.kind = 2; e.data = 32'd0; e.due = t;
      sbq.push_back(e);
      $display("txn cyc=%0d ERR  addr=%h rd=%0b wr=%0b", t, a, rdn, wrn);
      @(posedge clk); #1;
      idle_bus();
    end else begin
      idx   = int'(a >> 2);
      st_lo = t;
      st_hi = t + LAT;
      if (wrn) begin
        ref_mem[idx] = d;
        e.kind = 1; e.data = d;
      end else begin
        e.kind = 0; e.data = ref_mem[idx];
      end
      e.due = t + LAT + 1;
      sbq.push_back(e);
      $display("txn cyc=%0d %s addr=%h data=%h junk=%0b", t, wrn ? "WR " : "RD ", a, e.data, junk);
      got = 1'b0;
      for (int k = 0; k < 40; k++) begin
        @(posedge clk); #1;
        if (bus.ready) begin
          got = 1'b1;
          break;
        end
        if (junk) begin
          bus.addr     = $urandom;
          bus.wd       = $urandom;
          bus.MemRead  = 1'($urandom);
          bus.MemWrite = 1'($urandom);
        end
      end
      if (!got) timeout("main_ready");
      idle_bus();
    end
  endtask

  // Monitor: stall window every cycle, and pops the scoreboard on ready/err.
  logic [31:0] exp_rd_m = 32'd0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_rd_m = 32'd0;
      chk("stall_in_reset", {31'd0, bus.stall}, 32'd0);
      chk("err_in_reset", {31'd0, bus.err}, 32'd0);
    end else begin
      chk("stall", {31'd0, bus.stall}, {31'd0, (cyc >= st_lo) && (cyc <= st_hi)});
      if (bus.ready && bus.err) chk("ready_err_overlap", 32'd1, 32'd0);
      if (bus.ready || bus.err) begin
        if (sbq.size() == 0) begin
          chk("unexpected_response", {31'd0, bus.ready}, {31'd0, bus.err});
          chk("unexpected_response_any", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("resp_type", {31'd0, bus.err}, {31'd0, e.kind == 2});
          chk("resp_cycle", cyc, e.due);
          if (e.kind == 0) exp_rd_m = e.data;
        end
      end
      chk("rd", bus.rd, exp_rd_m);
    end
  end

  // Latency extremes on small separate instances.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sweep
      localparam int L = (gi == 0) ? 1 : 15;
      dmem_wait_responder_if sbus ();
      dmem_wait_responder #(.DEPTH_WORDS(16), .LATENCY(L)) u_dut (
        .clk (clk),
        .rst (rst_sw),
        .bus (sbus)
      );
      initial begin
        int          t;
        int          stalls;
        int          rdy_at;
        bit          got;
        logic [31:0] data;
        data          = 32'hC0DE_0000 | 32'(L);
        sbus.MemRead  = 1'b0;
        sbus.MemWrite = 1'b0;
        sbus.addr     = 32'd0;
        sbus.wd       = 32'd0;
        repeat (6) @(posedge clk);
        #1;
        sbus.MemWrite = 1'b1;
        sbus.addr     = 32'd4;
        sbus.wd       = data;
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
          @(posedge clk); #1;
          if (sbus.ready) begin got = 1'b1; break; end
        end
        if (!got) timeout("sweep_write");
        sbus.MemWrite = 1'b0;
        @(posedge clk); #1;
        sbus.MemRead = 1'b1;
        t      = cyc;
        stalls = 0;
        rdy_at = -1;
        for (int k = 0; k < 40; k++) begin
          @(negedge clk);
          if (sbus.stall) stalls++;
          if (sbus.ready) begin rdy_at = cyc; break; end
        end
        sbus.MemRead = 1'b0;
        $display("txn sweep L=%0d read issued cyc=%0d ready cyc=%0d stalls=%0d rd=%h", L, t, rdy_at, stalls, sbus.rd);
        chk("sweep_ready_latency", rdy_at - t, L + 1);
        chk("sweep_stall_cycles", stalls, L + 1);
        chk("sweep_rd", sbus.rd, data);
        sweep_done_cnt++;
      end
    end
  endgenerate

  initial begin
    int r;
    int idx;
    rst    = 1'b1;
    rst_sw = 1'b1;
    idle_bus();
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    rst_sw = 1'b0;

    for (int i = 0; i < DEPTH; i++) issue(1'b0, 1'b1, 32'(i * 4), $urandom, 1'b0);

    issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    issue(1'b1, 1'b0, 32'h10, 32'd0, 1'b0);

    issue(1'b1, 1'b0, 32'h13, 32'd0, 1'b0);
    issue(1'b1, 1'b1, 32'h14, 32'd0, 1'b0);
    issue(1'b1, 1'b0, 32'(4 * DEPTH), 32'd0, 1'b0);

    issue(1'b1, 1'b0, 32'h0, 32'd0, 1'b0);
    issue(1'b1, 1'b0, 32'h4, 32'd0, 1'b0);

    issue(1'b0, 1'b1, 32'h8, 32'h1111, 1'b1);

    // Reset during the BUSY phase of a write must leave the old word intact.
    issue(1'b0, 1'b1, 32'h20, 32'hAAAA5555, 1'b0);
    @(posedge clk); #1;
    bus.MemWrite = 1'b1;
    bus.addr     = 32'h20;
    bus.wd       = 32'h12345678;
    st_lo = cyc;
    st_hi = cyc + LAT;
    $display("txn cyc=%0d WR  addr=%h data=%h (reset follows)", cyc, 32'h20, 32'h12345678);
    @(posedge clk); #1;
    rst   = 1'b1;
    st_hi = cyc - 1;
    idle_bus();
    @(posedge clk); #1;
    rst = 1'b0;
    issue(1'b1, 1'b0, 32'h20, 32'd0, 1'b0);

    for (int n = 0; n < 300; n++) begin
      r   = int'($urandom_range(0, 9));
      idx = int'($urandom_range(0, DEPTH - 1));
      if (r == 0) begin
        case ($urandom_range(0, 3))
          0: issue(1'b1, 1'b0, 32'(idx * 4 + int'($urandom_range(1, 3))), 32'd0, 1'b0);
          1: issue(1'b1, 1'b1, 32'(idx * 4), $urandom, 1'b0);
          2: issue(1'b0, 1'b1, 32'((DEPTH + int'($urandom_range(0, 1000))) * 4), $urandom, 1'b0);
          default: issue(1'b1, 1'b0, 32'h8000_0000, 32'd0, 1'b0);
        endcase
      end else begin
        issue(r < 5, r >= 5, 32'(idx * 4), $urandom, 1'($urandom));
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    for (int i = 0; i < DEPTH; i++) issue(1'b1, 1'b0, 32'(i * 4), 32'd0, 1'b0);

    for (int k = 0; k < 400; k++) begin
      if (sbq.size() == 0 && sweep_done_cnt == 2) break;
      @(posedge clk);
    end
    if (sbq.size() != 0 || sweep_done_cnt != 2) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d responses outstanding, %0d of 2 sweeps done", sbq.size(), sweep_done_cnt);
    end
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
